// File: rtl/bridge_mmio_pkg.sv
// Shared state encoding and address-map constants for the MMIO bridge.
package bridge_mmio_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

    // Default map: DM, timer 0, timer 1 (inclusive bounds).
    localparam logic [31:0] DM_BASE  = 32'h0000_0000;
    localparam logic [31:0] DM_LIMIT = 32'h0000_2fff;
    localparam logic [31:0] T0_BASE  = 32'h0000_7f00;
    localparam logic [31:0] T0_LIMIT = 32'h0000_7f0b;
    localparam logic [31:0] T1_BASE  = 32'h0000_7f10;
    localparam logic [31:0] T1_LIMIT = 32'h0000_7f1b;

    localparam logic [3:0] BYTEEN_WORD = 4'b1111;

endpackage

// File: rtl/bridge_mmio_if.sv
// CPU-side request/response bus of the MMIO bridge.
interface bridge_mmio_if;

    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_byteen;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        cpu_err;

    // CPU side drives the request and receives the response strobe.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_byteen,
        input  cpu_ready, cpu_rdata, cpu_err
    );

    // Bridge side.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_byteen,
        output cpu_ready, cpu_rdata, cpu_err
    );

endinterface

// File: rtl/bridge_mmio_decoder.sv
// Combinational address decoder: one-hot slot select plus access-error flag.
module bridge_mmio_decoder
    import bridge_mmio_pkg::*;
#(
    parameter int unsigned         N_DEV     = 3,
    parameter logic [N_DEV*32-1:0] DEV_BASE  = {T1_BASE, T0_BASE, DM_BASE},
    parameter logic [N_DEV*32-1:0] DEV_LIMIT = {T1_LIMIT, T0_LIMIT, DM_LIMIT},
    parameter logic [N_DEV-1:0]    WORD_ONLY = 3'b110
) (
    input  logic [31:0]      addr,
    input  logic             we,
    input  logic [3:0]       byteen,
    output logic [N_DEV-1:0] sel,
    output logic             err
);

    logic found;
    logic wo_err;

    // Priority decode: the lowest-index slot containing the address wins.
    always_comb begin
        sel    = '0;
        found  = 1'b0;
        wo_err = 1'b0;
        for (int unsigned i = 0; i < N_DEV; i++) begin
            if (!found && (addr >= DEV_BASE[32*i +: 32]) && (addr <= DEV_LIMIT[32*i +: 32])) begin
                sel[i] = 1'b1;
                found  = 1'b1;
                wo_err = WORD_ONLY[i] & we & (byteen != BYTEEN_WORD);
            end
        end
        err = ~found | wo_err;
    end

endmodule

// File: rtl/bridge_mmio.sv
// CPU-to-MMIO bridge with wait states, timeout bus error and registered interrupts.
module bridge_mmio
    import bridge_mmio_pkg::*;
#(
    parameter int unsigned         N_DEV     = 3,
    parameter logic [N_DEV*32-1:0] DEV_BASE  = {T1_BASE, T0_BASE, DM_BASE},
    parameter logic [N_DEV*32-1:0] DEV_LIMIT = {T1_LIMIT, T0_LIMIT, DM_LIMIT},
    parameter logic [N_DEV-1:0]    WORD_ONLY = 3'b110,
    parameter int unsigned         TIMEOUT   = 15
) (
    input  logic                clk,
    input  logic                reset_n,
    bridge_mmio_if.slave        cpu,
    output logic [N_DEV-1:0]    dev_sel,
    output logic                dev_we,
    output logic [31:0]         dev_addr,
    output logic [31:0]         dev_wdata,
    output logic [3:0]          dev_byteen,
    input  logic [N_DEV-1:0]    dev_ready,
    input  logic [N_DEV*32-1:0] dev_rdata,
    input  logic [N_DEV-1:0]    dev_irq,
    output logic [N_DEV-1:0]    hwint
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [N_DEV-1:0]   sel_q;
    logic               we_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [3:0]         byteen_q;
    logic [31:0]        rdata_q;
    logic               err_q;
    logic [N_DEV-1:0]   hwint_q;

    logic [N_DEV-1:0]   dec_sel;
    logic               dec_err;
    logic [31:0]        rdata_mux;
    logic               sel_ready;
    logic               timed_out;

    bridge_mmio_decoder #(
        .N_DEV     (N_DEV),
        .DEV_BASE  (DEV_BASE),
        .DEV_LIMIT (DEV_LIMIT),
        .WORD_ONLY (WORD_ONLY)
    ) u_decoder (
        .addr   (cpu.cpu_addr),
        .we     (cpu.cpu_we),
        .byteen (cpu.cpu_byteen),
        .sel    (dec_sel),
        .err    (dec_err)
    );

    // Read data of the selected slot; sel_q is one-hot so OR-ing acts as a mux.
    always_comb begin
        rdata_mux = '0;
        for (int unsigned i = 0; i < N_DEV; i++) begin
            if (sel_q[i]) rdata_mux = rdata_mux | dev_rdata[32*i +: 32];
        end
    end

    // Only the selected slot's ready counts.
    assign sel_ready = |(dev_ready & sel_q);
    assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= StIdle;
        else          state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (cpu.cpu_req) state_d = dec_err ? StResp : StAccess;
            StAccess: if (sel_ready || timed_out) state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Request capture, wait counter and response registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            byteen_q <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cpu.cpu_req) begin
                        if (dec_err) begin
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end else begin
                            sel_q    <= dec_sel;
                            we_q     <= cpu.cpu_we;
                            addr_q   <= cpu.cpu_addr;
                            wdata_q  <= cpu.cpu_wdata;
                            byteen_q <= cpu.cpu_byteen;
                            cnt_q    <= '0;
                        end
                    end
                end
                StAccess: begin
                    if (sel_ready) begin
                        rdata_q <= we_q ? '0 : rdata_mux;
                        err_q   <= 1'b0;
                        sel_q   <= '0;
                    end else if (timed_out) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        sel_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Interrupt vector is resampled every cycle regardless of bus activity.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) hwint_q <= '0;
        else          hwint_q <= dev_irq;
    end

    // Outputs; the response is presented only during the strobe cycle.
    always_comb begin
        cpu.cpu_ready = (state_q == StResp);
        cpu.cpu_err   = (state_q == StResp) & err_q;
        cpu.cpu_rdata = (state_q == StResp) ? rdata_q : '0;
        dev_sel       = sel_q;
        dev_we        = we_q;
        dev_addr      = addr_q;
        dev_wdata     = wdata_q;
        dev_byteen    = byteen_q;
        hwint         = hwint_q;
    end

endmodule

// File: tb/tb_bridge_mmio.sv
// Self-checking bench for bridge_mmio using a response scoreboard.
module tb_bridge_mmio;

    localparam logic [31:0] RD0 = 32'hDEAD_BEEF;
    localparam logic [31:0] RD1 = 32'h1234_5678;
    localparam logic [31:0] RD2 = 32'hCAFE_F00D;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          sel_cycles;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  dev_sel;
    logic        dev_we;
    logic [31:0] dev_addr;
    logic [31:0] dev_wdata;
    logic [3:0]  dev_byteen;
    logic [2:0]  dev_ready;
    logic [95:0] dev_rdata;
    logic [2:0]  dev_irq;
    logic [2:0]  hwint;

    int          ready_delay;
    logic [2:0]  stray_ready;
    int          wait_cnt;
    int          n_tests = 0;
    int          n_fail = 0;
    exp_t        sb[$];

    always #5 clk = ~clk;

    bridge_mmio_if cpu_bus ();

    bridge_mmio dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu        (cpu_bus),
        .dev_sel    (dev_sel),
        .dev_we     (dev_we),
        .dev_addr   (dev_addr),
        .dev_wdata  (dev_wdata),
        .dev_byteen (dev_byteen),
        .dev_ready  (dev_ready),
        .dev_rdata  (dev_rdata),
        .dev_irq    (dev_irq),
        .hwint      (hwint)
    );

    // Device model: selected slot answers after ready_delay selected cycles.
    assign dev_rdata = {RD2, RD1, RD0};
    assign dev_ready = stray_ready | (dev_sel & {3{wait_cnt >= ready_delay}});

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)           wait_cnt <= 0;
        else if (dev_sel == '0) wait_cnt <= 0;
        else                    wait_cnt <= wait_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // Issue one access, hold it until cpu_ready, compare against the scoreboard.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [2:0] exp_sel, input int delay,
                          input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                          input int irq_cyc);
        exp_t e;
        int   cyc;
        int   sel_cyc;
        bit   got;
        e.rdata      = exp_rdata;
        e.err        = exp_err;
        e.lat        = exp_lat;
        e.sel_cycles = (exp_sel != 3'b000) ? exp_lat - 1 : 0;
        sb.push_back(e);
        ready_delay          = delay;
        cpu_bus.cpu_req      = 1'b1;
        cpu_bus.cpu_we       = we;
        cpu_bus.cpu_addr     = addr;
        cpu_bus.cpu_wdata    = wdata;
        cpu_bus.cpu_byteen   = be;
        cyc     = 0;
        sel_cyc = 0;
        got     = 1'b0;
        while (!got && cyc < 64) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == irq_cyc + 1) check_eq("hwint", 64'(hwint), 64'(3'b101));
            if (cyc == irq_cyc) dev_irq = 3'b101;
            if (dev_sel != 3'b000) begin
                sel_cyc++;
                check_eq("dev_sel", 64'(dev_sel), 64'(exp_sel));
                check_eq("dev_addr", 64'(dev_addr), 64'(addr));
                check_eq("dev_ctl", 64'({dev_we, dev_byteen, dev_wdata}), 64'({we, be, wdata}));
            end
            if (cpu_bus.cpu_ready) begin
                got = 1'b1;
                e = sb.pop_front();
                check_eq("rdata", 64'(cpu_bus.cpu_rdata), 64'(e.rdata));
                check_eq("err", 64'(cpu_bus.cpu_err), 64'(e.err));
                check_eq("latency", 64'(cyc), 64'(e.lat));
                check_eq("sel_cycles", 64'(sel_cyc), 64'(e.sel_cycles));
            end
        end
        check_eq("resp_seen", 64'(got), 64'(1));
        if (!got && sb.size() != 0) void'(sb.pop_front());
        cpu_bus.cpu_req = 1'b0;
        @(posedge clk);
        #1;
        check_eq("ready_pulse", 64'(cpu_bus.cpu_ready), 64'(0));
    endtask

    initial begin
        int spurious;
        cpu_bus.cpu_req    = 1'b0;
        cpu_bus.cpu_we     = 1'b0;
        cpu_bus.cpu_addr   = '0;
        cpu_bus.cpu_wdata  = '0;
        cpu_bus.cpu_byteen = '0;
        dev_irq            = '0;
        ready_delay        = 0;
        stray_ready        = '0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", 64'(cpu_bus.cpu_ready), 64'(0));
        check_eq("rst_err", 64'(cpu_bus.cpu_err), 64'(0));
        check_eq("rst_rdata", 64'(cpu_bus.cpu_rdata), 64'(0));
        check_eq("rst_sel", 64'(dev_sel), 64'(0));
        check_eq("rst_req", 64'({dev_we, dev_byteen, dev_addr}), 64'(0));
        check_eq("rst_hwint", 64'(hwint), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // DM read, zero wait
        stray_ready = 3'b001;
        access(1'b0, 32'h0000_1000, 32'h0, 4'hF, 3'b001, 0, RD0, 1'b0, 2, -5);
        stray_ready = 3'b000;
        // T0 word write, 3 wait cycles, interrupt raised mid-access
        access(1'b1, 32'h0000_7f04, 32'hA5A5_0001, 4'hF, 3'b010, 3, 32'h0, 1'b0, 5, 2);
        // T0 partial write rejected
        access(1'b1, 32'h0000_7f04, 32'hA5A5_0002, 4'b0011, 3'b000, 0, 32'h0, 1'b1, 1, -5);
        // Unmapped read
        access(1'b0, 32'h0000_5000, 32'h0, 4'hF, 3'b000, 0, 32'h0, 1'b1, 1, -5);
        // T1 timeout; unselected slots' ready must be ignored
        stray_ready = 3'b011;
        access(1'b0, 32'h0000_7f10, 32'h0, 4'hF, 3'b100, 1000, 32'h0, 1'b1, 16, -5);
        stray_ready = 3'b000;
        // Boundaries and the follow-up after timeout
        access(1'b0, 32'h0000_7f1b, 32'h0, 4'hF, 3'b100, 1, RD2, 1'b0, 3, -5);
        access(1'b0, 32'h0000_2fff, 32'h0, 4'hF, 3'b001, 0, RD0, 1'b0, 2, -5);
        access(1'b0, 32'h0000_3000, 32'h0, 4'hF, 3'b000, 0, 32'h0, 1'b1, 1, -5);
        access(1'b0, 32'h0000_7f0b, 32'h0, 4'hF, 3'b010, 2, RD1, 1'b0, 4, -5);
        access(1'b0, 32'h0000_7f0c, 32'h0, 4'hF, 3'b000, 0, 32'h0, 1'b1, 1, -5);
        // DM accepts partial writes; T1 does not
        access(1'b1, 32'h0000_0010, 32'h0000_BEEF, 4'b0011, 3'b001, 0, 32'h0, 1'b0, 2, -5);
        access(1'b1, 32'h0000_7f14, 32'h1111_2222, 4'b1100, 3'b000, 0, 32'h0, 1'b1, 1, -5);

        // Reset in the middle of an ACCESS wait
        check_eq("hwint_pre", 64'(hwint), 64'(3'b101));
        ready_delay        = 1000;
        cpu_bus.cpu_req    = 1'b1;
        cpu_bus.cpu_we     = 1'b0;
        cpu_bus.cpu_addr   = 32'h0000_7f14;
        cpu_bus.cpu_byteen = 4'hF;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check_eq("pre_rst_sel", 64'(dev_sel), 64'(3'b100));
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("arst_sel", 64'(dev_sel), 64'(0));
        check_eq("arst_ready", 64'(cpu_bus.cpu_ready), 64'(0));
        check_eq("arst_hwint", 64'(hwint), 64'(0));
        cpu_bus.cpu_req = 1'b0;
        dev_irq         = 3'b000;
        @(negedge clk);
        reset_n = 1'b1;
        spurious = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (cpu_bus.cpu_ready) spurious++;
        end
        check_eq("no_spurious", 64'(spurious), 64'(0));
        access(1'b0, 32'h0000_0004, 32'h0, 4'hF, 3'b001, 0, RD0, 1'b0, 2, -5);

        check_eq("sb_empty", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
